// File: rtl/fp_add_operand_loader_if.sv
// Operand-loader bus: byte stream in, operand pair plus special-value flags out.
// The DUT uses the slave modport; whoever feeds bytes and consumes pairs uses master.
interface fp_add_operand_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hidden_a;
    logic        hidden_b;
    logic        op_valid;
    logic        op_ready;
    logic        nan_flag;
    logic        inf_flag;
    logic        zero_flag;

    modport master (
        output in_data, in_valid, flush, op_ready,
        input  in_ready, op_a, op_b, hidden_a, hidden_b, op_valid,
        input  nan_flag, inf_flag, zero_flag
    );

    modport slave (
        input  in_data, in_valid, flush, op_ready,
        output in_ready, op_a, op_b, hidden_a, hidden_b, op_valid,
        output nan_flag, inf_flag, zero_flag
    );
endinterface

// File: rtl/fp_add_operand_loader.sv
// Assembles two IEEE-754 singles from an LSB-first byte stream and presents them to the adder.
// Define FP_SPECIAL_DETECT_EN to build the NaN/Inf/zero classifier; otherwise the flags are tied low.
module fp_add_operand_loader (
    input  logic                         clk,
    input  logic                         rst,
    fp_add_operand_loader_if.slave       bus
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        accept;
    logic        enter_present;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic        hidden_a_q;
    logic        hidden_b_q;
    logic [7:0]  b_exp_full;

    // A byte offered in the same cycle as a flush is dropped, not stored.
    assign accept        = bus.in_valid && (state != PRESENT) && !bus.flush;
    assign enter_present = accept && (state == LOAD_B) && (count == 2'd3);
    assign b_exp_full    = {bus.in_data[6:0], op_b_q[23]};

    always_comb begin
        state_next = state;
        count_next = count;
        if (bus.flush) begin
            state_next = LOAD_A;
            count_next = 2'd0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        count_next = count + 2'd1;
                        if (count == 2'd3) begin
                            state_next = LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        count_next = count + 2'd1;
                        if (count == 2'd3) begin
                            state_next = PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (bus.op_ready) begin
                        state_next = LOAD_A;
                        count_next = 2'd0;
                    end
                end
                default: begin
                    state_next = LOAD_A;
                    count_next = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD_A;
            count <= 2'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q <= 32'd0;
            op_b_q <= 32'd0;
        end else if (accept) begin
            if (state == LOAD_A) begin
                op_a_q[8*count +: 8] <= bus.in_data;
            end else begin
                op_b_q[8*count +: 8] <= bus.in_data;
            end
        end
    end

    // B's top byte is still on in_data at the entry edge, so its exponent is taken from there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hidden_a_q <= 1'b0;
            hidden_b_q <= 1'b0;
        end else if (enter_present) begin
            hidden_a_q <= |op_a_q[30:23];
            hidden_b_q <= |b_exp_full;
        end
    end

`ifdef FP_SPECIAL_DETECT_EN
    logic [30:0] b_mag_full;
    logic        nan_q;
    logic        inf_q;
    logic        zero_q;
    logic        nan_next;

    assign b_mag_full = {bus.in_data[6:0], op_b_q[23:0]};

    function automatic logic is_nan(input logic [30:0] mag);
        return (&mag[30:23]) && (|mag[22:0]);
    endfunction

    function automatic logic is_inf(input logic [30:0] mag);
        return (&mag[30:23]) && !(|mag[22:0]);
    endfunction

    assign nan_next = is_nan(op_a_q[30:0]) || is_nan(b_mag_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_q  <= 1'b0;
            inf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (enter_present) begin
            nan_q  <= nan_next;
            inf_q  <= !nan_next && (is_inf(op_a_q[30:0]) || is_inf(b_mag_full));
            zero_q <= !(|op_a_q[30:0]) && !(|b_mag_full);
        end
    end

    assign bus.nan_flag  = nan_q;
    assign bus.inf_flag  = inf_q;
    assign bus.zero_flag = zero_q;
`else
    assign bus.nan_flag  = 1'b0;
    assign bus.inf_flag  = 1'b0;
    assign bus.zero_flag = 1'b0;
`endif

    assign bus.in_ready = (state != PRESENT);
    assign bus.op_valid = (state == PRESENT);
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.hidden_a = hidden_a_q;
    assign bus.hidden_b = hidden_b_q;

endmodule

// File: tb/tb_fp_add_operand_loader.sv
// Randomized bench for fp_add_operand_loader against an arithmetic model of IEEE-754 classification.
// Flag expectations follow FP_SPECIAL_DETECT_EN the same way the design build does.
module tb_fp_add_operand_loader;

    logic clk = 1'b0;
    logic rst;
    int   check_count = 0;
    int   error_count = 0;

`ifdef FP_SPECIAL_DETECT_EN
    localparam bit DETECT = 1'b1;
`else
    localparam bit DETECT = 1'b0;
`endif

    always #5 clk = ~clk;

    fp_add_operand_loader_if bus ();

    fp_add_operand_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: field extraction by plain division/modulo.
    function automatic int exponent_of(input logic [31:0] x);
        return int'((x / 32'd8388608) % 32'd256);
    endfunction

    function automatic logic [31:0] mantissa_of(input logic [31:0] x);
        return x % 32'd8388608;
    endfunction

    function automatic bit model_nan(input logic [31:0] x);
        return (exponent_of(x) == 255) && (mantissa_of(x) != 0);
    endfunction

    function automatic bit model_inf(input logic [31:0] x);
        return (exponent_of(x) == 255) && (mantissa_of(x) == 0);
    endfunction

    task automatic check_present(input logic [31:0] a, input logic [31:0] b);
        bit exp_nan;
        bit exp_inf;
        bit exp_zero;
        exp_nan  = DETECT && (model_nan(a) || model_nan(b));
        exp_inf  = DETECT && !exp_nan && (model_inf(a) || model_inf(b));
        exp_zero = DETECT && ((a % 32'h8000_0000) == 0) && ((b % 32'h8000_0000) == 0);
        checkOutput("op_valid_present", bus.op_valid, 1);
        checkOutput("in_ready_present", bus.in_ready, 0);
        checkOutput("op_a", bus.op_a, a);
        checkOutput("op_b", bus.op_b, b);
        checkOutput("hidden_a", bus.hidden_a, exponent_of(a) != 0);
        checkOutput("hidden_b", bus.hidden_b, exponent_of(b) != 0);
        checkOutput("nan_flag", bus.nan_flag, exp_nan);
        checkOutput("inf_flag", bus.inf_flag, exp_inf);
        checkOutput("zero_flag", bus.zero_flag, exp_zero);
    endtask

    // Offers the first n bytes of the pair, with random idle cycles in between.
    task automatic send_bytes(input logic [31:0] a, input logic [31:0] b, input int n);
        logic [63:0] pair;
        pair = {b, a};
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end
            @(negedge clk);
            checkOutput("in_ready_load", bus.in_ready, 1);
            checkOutput("op_valid_load", bus.op_valid, 0);
            bus.in_valid = 1'b1;
            bus.in_data  = pair[8*i +: 8];
        end
    endtask

    // Full transaction: load, present, hold off op_ready for 'hold' cycles, then consume.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int hold);
        send_bytes(a, b, 8);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_present(a, b);
        for (int h = 0; h < hold; h++) begin
            bus.op_ready = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
            check_present(a, b);
        end
        bus.in_valid = 1'b0;
        bus.op_ready = 1'b1;
        @(negedge clk);
        checkOutput("op_valid_consumed", bus.op_valid, 0);
        checkOutput("in_ready_after", bus.in_ready, 1);
        bus.op_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_op_valid"}, bus.op_valid, 0);
        checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
        checkOutput({tag, "_op_a"}, bus.op_a, 0);
        checkOutput({tag, "_op_b"}, bus.op_b, 0);
        checkOutput({tag, "_hidden"}, {bus.hidden_a, bus.hidden_b}, 0);
        checkOutput({tag, "_flags"}, {bus.nan_flag, bus.inf_flag, bus.zero_flag}, 0);
    endtask

    function automatic logic [31:0] random_operand();
        logic [31:0] sign;
        logic [31:0] mant;
        sign = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'd0;
        mant = $urandom % 32'd8388608;
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return sign;
            2:       return sign + ((mant == 0) ? 32'd1 : mant);
            3:       return sign + 32'd255 * 32'd8388608;
            4:       return sign + 32'd255 * 32'd8388608 + ((mant == 0) ? 32'd5 : mant);
            default: return sign + 32'($urandom_range(1, 254)) * 32'd8388608 + mant;
        endcase
    endfunction

    initial begin
        rst          = 1'b1;
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.op_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_post_reset", bus.in_ready, 1);

        applyStimulus(32'h3F80_0000, 32'h4000_0000, 0);
        applyStimulus(32'h0000_0001, 32'h8000_0000, 1);
        applyStimulus(32'h0000_0000, 32'h8000_0000, 0);
        applyStimulus(32'h7FC0_0000, 32'h7F80_0000, 2);
        applyStimulus(32'h3F80_0000, 32'h7F80_0000, 0);
        applyStimulus(32'hC120_0000, 32'h4049_0FDB, 5);

        // Flush mid-B with a byte offered in the same cycle.
        send_bytes(32'hDEAD_BEEF, 32'h1234_5678, 7);
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush_op_valid", bus.op_valid, 0);
        checkOutput("flush_in_ready", bus.in_ready, 1);
        applyStimulus(32'h4120_0000, 32'hBF00_0000, 1);

        // Flush in PRESENT beats a simultaneous op_ready.
        send_bytes(32'h3F00_0000, 32'h3E80_0000, 8);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_present(32'h3F00_0000, 32'h3E80_0000);
        bus.flush    = 1'b1;
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.op_ready = 1'b0;
        checkOutput("flush_present_op_valid", bus.op_valid, 0);
        checkOutput("flush_present_in_ready", bus.in_ready, 1);
        applyStimulus(32'h0080_0000, 32'h007F_FFFF, 0);

        // Asynchronous reset while loading B.
        send_bytes(32'h4B00_00FF, 32'hC0A0_0000, 6);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_async_reset", bus.in_ready, 1);
        applyStimulus(32'h4040_0000, 32'hFF80_0000, 0);

        for (int t = 0; t < 40; t++) begin
            applyStimulus(random_operand(), random_operand(), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
